// File: rtl/coax_txrx_sequencer.sv
// rtl/coax_txrx_sequencer.sv - half-duplex coax transmit/turnaround/receive transaction sequencer
module coax_txrx_sequencer #(
  parameter int TURNAROUND_CLOCKS       = 32,
  parameter int RESPONSE_TIMEOUT_CLOCKS = 2048,
  parameter int TX_START_CLOCKS         = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       expect_response,
  input  logic       abort,
  input  logic       tx_active,
  input  logic       tx_empty,
  input  logic       rx_active,
  input  logic       rx_error,
  output logic       tx_start_strobe,
  output logic       rx_reset,
  output logic       rx_enable,
  output logic       busy,
  output logic       done,
  output logic [2:0] status
);

  typedef enum logic [2:0] {
    S_IDLE, S_TX_ARM, S_TX_RUN, S_TURNAROUND, S_RX_WAIT, S_RX_RUN, S_DONE
  } state_t;

  localparam logic [2:0] ST_OK       = 3'd0;
  localparam logic [2:0] ST_NO_DATA  = 3'd1;
  localparam logic [2:0] ST_TIMEOUT  = 3'd2;
  localparam logic [2:0] ST_RX_ERROR = 3'd3;
  localparam logic [2:0] ST_ABORTED  = 3'd4;
  localparam logic [2:0] ST_TX_STALL = 3'd5;

  localparam int ARM_W = $clog2(TX_START_CLOCKS) + 1;
  localparam int TA_W  = $clog2(TURNAROUND_CLOCKS) + 1;
  localparam int TO_W  = $clog2(RESPONSE_TIMEOUT_CLOCKS) + 1;

  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(TX_START_CLOCKS - 1);
  localparam logic [TA_W-1:0]  TA_LAST  = TA_W'(TURNAROUND_CLOCKS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(RESPONSE_TIMEOUT_CLOCKS - 1);

  state_t            state_q, state_d;
  logic [2:0]        status_q, status_d;
  logic [ARM_W-1:0]  arm_cnt;
  logic [TA_W-1:0]   ta_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              expect_q;
  logic              accept_tx;

  assign accept_tx = (state_q == S_IDLE) && start && !tx_empty;

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (tx_empty) begin
            state_d  = S_DONE;
            status_d = ST_NO_DATA;
          end else begin
            state_d = S_TX_ARM;
          end
        end
      end
      S_TX_ARM: begin
        if (tx_active) begin
          state_d = S_TX_RUN;
        end else if (arm_cnt >= ARM_LAST) begin
          state_d  = S_DONE;
          status_d = ST_TX_STALL;
        end
      end
      S_TX_RUN: begin
        if (!tx_active) begin
          if (expect_q) begin
            state_d = S_TURNAROUND;
          end else begin
            state_d  = S_DONE;
            status_d = ST_OK;
          end
        end
      end
      S_TURNAROUND: begin
        if (ta_cnt >= TA_LAST) state_d = S_RX_WAIT;
      end
      S_RX_WAIT: begin
        // A frame starting on the timeout cycle still counts as a response.
        if (rx_error) begin
          state_d  = S_DONE;
          status_d = ST_RX_ERROR;
        end else if (rx_active) begin
          state_d = S_RX_RUN;
        end else if (to_cnt >= TO_LAST) begin
          state_d  = S_DONE;
          status_d = ST_TIMEOUT;
        end
      end
      S_RX_RUN: begin
        if (rx_error) begin
          state_d  = S_DONE;
          status_d = ST_RX_ERROR;
        end else if (!rx_active) begin
          state_d  = S_DONE;
          status_d = ST_OK;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
      state_d  = S_DONE;
      status_d = ST_ABORTED;
    end
  end

  // Counters hold zero outside their own state, so every entry starts from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      status_q        <= ST_OK;
      arm_cnt         <= '0;
      ta_cnt          <= '0;
      to_cnt          <= '0;
      expect_q        <= 1'b0;
      tx_start_strobe <= 1'b0;
      rx_reset        <= 1'b0;
    end else begin
      state_q         <= state_d;
      status_q        <= status_d;
      tx_start_strobe <= accept_tx;
      rx_reset        <= accept_tx;
      if (accept_tx) expect_q <= expect_response;
      if (state_q == S_TX_ARM && state_d == S_TX_ARM) begin
        if (arm_cnt != '1) arm_cnt <= arm_cnt + 1'b1;
      end else begin
        arm_cnt <= '0;
      end
      if (state_q == S_TURNAROUND && state_d == S_TURNAROUND) begin
        if (ta_cnt != '1) ta_cnt <= ta_cnt + 1'b1;
      end else begin
        ta_cnt <= '0;
      end
      if (state_q == S_RX_WAIT && state_d == S_RX_WAIT) begin
        if (to_cnt != '1) to_cnt <= to_cnt + 1'b1;
      end else begin
        to_cnt <= '0;
      end
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign rx_enable = (state_q == S_RX_WAIT) || (state_q == S_RX_RUN);
  assign status    = status_q;

endmodule

// File: tb/tb_coax_txrx_sequencer.sv
// tb/tb_coax_txrx_sequencer.sv - self-checking bench for coax_txrx_sequencer
module tb_coax_txrx_sequencer;

  localparam int TA = 32;
  localparam int TO = 2048;
  localparam int NV = 8;

  typedef struct {
    logic exp_rsp;
    logic tx_empty;
    int   tx_len;
    int   rx_delay;
    int   rx_len;
    int   err_at;
    int   abort_ph;
    int   abort_at;
    int   exp_status;
    int   exp_lat;
    int   exp_rx_lat;
    logic chk_ta;
  } vec_t;

  typedef struct {
    int   status;
    int   strobes;
    int   lat;
    int   rx_lat;
    logic chk_ta;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       expect_response = 1'b0;
  logic       abort = 1'b0;
  logic       tx_active = 1'b0;
  logic       tx_empty = 1'b0;
  logic       rx_active = 1'b0;
  logic       rx_error = 1'b0;
  logic       tx_start_strobe, rx_reset, rx_enable, busy, done;
  logic [2:0] status;

  coax_txrx_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .expect_response(expect_response),
    .abort(abort), .tx_active(tx_active), .tx_empty(tx_empty), .rx_active(rx_active),
    .rx_error(rx_error), .tx_start_strobe(tx_start_strobe), .rx_reset(rx_reset),
    .rx_enable(rx_enable), .busy(busy), .done(done), .status(status)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   done_seen = 0;
  int   start_cyc = 0;
  int   tx_fall_cyc = -100000;
  int   rx_en_rise_cyc = -100000;
  int   strobe_cnt = 0;
  logic prev_strobe = 1'b0;
  logic prev_rxr = 1'b0;
  logic force_abort = 1'b0;
  int   tx_left = 0, tx_idx = 0, rx_wait = 0, rx_left = 0, rx_idx = 0;
  logic rx_started = 1'b0, prev_en = 1'b0;
  vec_t cur;
  exp_t sb[$];
  vec_t vecs[NV];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard/monitor plus a reactive transmitter/receiver model, in one block to avoid races.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      strobe_cnt = 0;
    end else begin
      if (tx_start_strobe) strobe_cnt++;
      if (tx_start_strobe && prev_strobe) chk("strobe_one_cycle", 1, 0);
      if (rx_reset && prev_rxr) chk("rx_reset_one_cycle", 1, 0);
      if (done) begin
        done_seen++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("status", int'(status), e.status);
          chk("strobe_count", strobe_cnt, e.strobes);
          chk("rx_enable_at_done", int'(rx_enable), 0);
          if (e.lat >= 0) chk("latency_from_start", cyc - start_cyc, e.lat);
          if (e.rx_lat >= 0) chk("latency_from_rx_enable", cyc - rx_en_rise_cyc, e.rx_lat);
          if (e.chk_ta) chk("turnaround_clocks", rx_en_rise_cyc - tx_fall_cyc, TA);
        end
        strobe_cnt = 0;
      end
    end
    prev_strobe = tx_start_strobe;
    prev_rxr    = rx_reset;

    abort    = force_abort;
    rx_error = 1'b0;
    if (!reset_n) begin
      tx_left = 0; rx_left = 0; rx_started = 1'b0; prev_en = 1'b0;
      tx_active = 1'b0; rx_active = 1'b0;
    end else begin
      if (tx_start_strobe) begin
        tx_left = cur.tx_len; tx_idx = 0; rx_started = 1'b0;
      end
      if (tx_left > 0) begin
        tx_active = 1'b1;
        if (cur.abort_ph == 1 && tx_idx == cur.abort_at) abort = 1'b1;
        tx_idx++; tx_left--;
      end else begin
        if (tx_active) tx_fall_cyc = cyc + 1;
        tx_active = 1'b0;
      end
      if (rx_enable && !prev_en) begin
        rx_wait = cur.rx_delay; rx_en_rise_cyc = cyc;
      end else if (rx_enable && !rx_started && cur.rx_len > 0) begin
        if (rx_wait > 0) rx_wait--;
        else begin
          rx_started = 1'b1; rx_left = cur.rx_len; rx_idx = 0;
        end
      end
      if (rx_left > 0) begin
        rx_active = 1'b1;
        if (rx_idx == cur.err_at) rx_error = 1'b1;
        if (cur.abort_ph == 2 && rx_idx == cur.abort_at) abort = 1'b1;
        rx_idx++; rx_left--;
      end else begin
        rx_active = 1'b0;
      end
      prev_en = rx_enable;
    end
  end

  task automatic run_txn(input vec_t v, input bit push);
    exp_t e;
    @(negedge clk);
    cur = v;
    if (push) begin
      e.status  = v.exp_status;
      e.strobes = v.tx_empty ? 0 : 1;
      e.lat     = v.exp_lat;
      e.rx_lat  = v.exp_rx_lat;
      e.chk_ta  = v.chk_ta;
      sb.push_back(e);
    end
    start = 1'b1; expect_response = v.exp_rsp; tx_empty = v.tx_empty; start_cyc = cyc;
    @(negedge clk);
    start = 1'b0; expect_response = 1'b0; tx_empty = 1'b0;
  endtask

  task automatic wait_done(input int n0);
    int k = 0;
    while (done_seen == n0 && k < 6000) begin
      @(negedge clk); k++;
    end
    chk("done_arrived", done_seen, n0 + 1);
    k = 0;
    while ((tx_left > 0 || rx_left > 0) && k < 300) begin
      @(negedge clk); k++;
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int   n0;
    vec_t v;
    //          rsp empty txl rxd rxl err aph aat st lat  rxlat ta
    vecs[0] = '{1'b1, 1'b0, 100, 2, 50, -1, 0, 0, 0, -1,  -1, 1'b1};
    vecs[1] = '{1'b1, 1'b0,  10, 0,  0, -1, 0, 0, 2, -1,  TO, 1'b1};
    vecs[2] = '{1'b1, 1'b1,   0, 0,  0, -1, 0, 0, 1,  1,  -1, 1'b0};
    vecs[3] = '{1'b0, 1'b0,   5, 0,  0, -1, 0, 0, 0,  7,  -1, 1'b0};
    vecs[4] = '{1'b1, 1'b0,   6, 1, 20, -1, 2, 5, 4, -1,  -1, 1'b1};
    vecs[5] = '{1'b1, 1'b0,   6, 1, 20,  3, 0, 0, 3, -1,  -1, 1'b1};
    vecs[6] = '{1'b0, 1'b0,  20, 0,  0, -1, 1, 5, 4,  7,  -1, 1'b0};
    vecs[7] = '{1'b1, 1'b0,   0, 0,  0, -1, 0, 0, 5,  9,  -1, 1'b0};
    cur = vecs[0];

    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_status", int'(status), 0);
    chk("reset_rx_enable", int'(rx_enable), 0);
    chk("reset_strobe", int'(tx_start_strobe), 0);
    chk("reset_rx_reset", int'(rx_reset), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      n0 = done_seen;
      run_txn(vecs[i], 1'b1);
      wait_done(n0);
    end

    repeat (10) @(negedge clk);
    chk("status_held", int'(status), 5);

    // Reset in the middle of TX_RUN: outputs drop without a clock, no done follows.
    v = '{1'b1, 1'b0, 50, 0, 0, -1, 0, 0, 0, -1, -1, 1'b0};
    n0 = done_seen;
    run_txn(v, 1'b0);
    repeat (8) @(negedge clk);
    chk("pre_reset_busy", int'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_busy", int'(busy), 0);
    chk("async_status", int'(status), 0);
    chk("async_done", int'(done), 0);
    chk("async_rx_enable", int'(rx_enable), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("post_reset_idle", int'(busy), 0);
    chk("no_done_after_reset", done_seen, n0);

    // A second start while busy must not launch another transmission.
    v = '{1'b0, 1'b0, 30, 0, 0, -1, 0, 0, 0, 32, -1, 1'b0};
    n0 = done_seen;
    run_txn(v, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n0);

    force_abort = 1'b1;
    @(negedge clk);
    force_abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_busy", int'(busy), 0);
    chk("idle_abort_done_count", done_seen, n0 + 1);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
